// File: rtl/mdu_sequencer.sv
// Purpose: multi-cycle M-extension sequencer (iterative shift-add multiply, restoring divide, sign fix-up).
// Latency: start at T -> done at T+XLEN+2; divide-by-zero/overflow (and multiply with MDU_FAST_MUL_EN) at T+2.
// Backpressure: ready only in IDLE; start while busy is ignored; kill aborts to IDLE without a done pulse.
module mdu_sequencer #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] rs1_val,
    input  logic [XLEN-1:0] rs2_val,
    input  logic            kill,
    output logic            ready,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);
    localparam int CW = $clog2(XLEN);

    typedef enum logic [1:0] {S_IDLE, S_ITER, S_FIX, S_DONE} state_t;

    state_t              state, state_nxt;
    logic [2:0]          op;
    logic [XLEN-1:0]     a_abs, b_abs;
    logic                a_neg, b_neg;
    logic                special;      // result already final in acc; skip sign fix-up
    logic [2*XLEN-1:0]   acc;          // multiply: {partial, multiplier}; divide: {remainder, quotient}
    logic [CW-1:0]       count;

    // Incoming operand decode
    logic            a_sgn, b_sgn, rs1_neg, rs2_neg, div_zero, div_ovf, fast_mul;
    logic [XLEN-1:0] rs1_abs, rs2_abs;
    logic [2*XLEN-1:0] fast_prod;

    assign a_sgn    = (funct3 == 3'b001) || (funct3 == 3'b010) || (funct3 == 3'b100) || (funct3 == 3'b110);
    assign b_sgn    = (funct3 == 3'b001) || (funct3 == 3'b100) || (funct3 == 3'b110);
    assign rs1_neg  = a_sgn & rs1_val[XLEN-1];
    assign rs2_neg  = b_sgn & rs2_val[XLEN-1];
    assign rs1_abs  = rs1_neg ? (~rs1_val + 1'b1) : rs1_val;
    assign rs2_abs  = rs2_neg ? (~rs2_val + 1'b1) : rs2_val;
    assign div_zero = funct3[2] && (rs2_val == '0);
    assign div_ovf  = funct3[2] && !funct3[0] && (rs1_val == {1'b1, {(XLEN-1){1'b0}}}) && (&rs2_val);

`ifdef MDU_FAST_MUL_EN
    // Low 2*XLEN bits of the product of sign-extended operands equal the exact signed (XLEN+1)x(XLEN+1) product.
    logic [XLEN:0] fa, fb;
    assign fa        = {rs1_neg, rs1_val};
    assign fb        = {rs2_neg, rs2_val};
    assign fast_mul  = ~funct3[2];
    assign fast_prod = {{(XLEN-1){fa[XLEN]}}, fa} * {{(XLEN-1){fb[XLEN]}}, fb};
`else
    assign fast_mul  = 1'b0;
    assign fast_prod = '0;
`endif

    // One iteration step of each algorithm
    logic [XLEN:0]     mul_sum, rem_sh, rem_diff;
    logic [2*XLEN-1:0] mul_nxt, div_nxt;

    assign mul_sum  = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, a_abs} : '0);
    assign mul_nxt  = {mul_sum, acc[XLEN-1:1]};
    assign rem_sh   = acc[2*XLEN-1:XLEN-1];
    assign rem_diff = rem_sh - {1'b0, b_abs};
    assign div_nxt  = rem_diff[XLEN] ? {rem_sh[XLEN-1:0], acc[XLEN-2:0], 1'b0}
                                     : {rem_diff[XLEN-1:0], acc[XLEN-2:0], 1'b1};

    // Sign correction and result selection
    logic [2*XLEN-1:0] prod_c;
    logic [XLEN-1:0]   quo_c, rem_c, fix_val;

    assign prod_c = (!special && (a_neg ^ b_neg)) ? (~acc + 1'b1) : acc;
    assign quo_c  = (!special && (a_neg ^ b_neg)) ? (~acc[XLEN-1:0] + 1'b1) : acc[XLEN-1:0];
    assign rem_c  = (!special && a_neg) ? (~acc[2*XLEN-1:XLEN] + 1'b1) : acc[2*XLEN-1:XLEN];

    // Select the architectural result for the latched op
    always_comb begin
        fix_val = rem_c;
        case (op)
            3'b000:                 fix_val = prod_c[XLEN-1:0];
            3'b001, 3'b010, 3'b011: fix_val = prod_c[2*XLEN-1:XLEN];
            3'b100, 3'b101:         fix_val = quo_c;
            default:                fix_val = rem_c;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    // Next-state logic; kill wins over everything
    always_comb begin
        state_nxt = state;
        if (kill) begin
            state_nxt = S_IDLE;
        end else begin
            case (state)
                S_IDLE: if (start) state_nxt = (div_zero || div_ovf || fast_mul) ? S_FIX : S_ITER;
                S_ITER: if (count == CW'(XLEN-1)) state_nxt = S_FIX;
                S_FIX:  state_nxt = S_DONE;
                default: state_nxt = S_IDLE;
            endcase
        end
    end

    // Handshake outputs; kill in the DONE cycle masks the pulse
    always_comb begin
        ready = (state == S_IDLE);
        busy  = (state != S_IDLE);
        done  = (state == S_DONE) && !kill;
    end

    // Datapath: latch on accept, iterate in ITER, register result in FIX
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op      <= '0;
            a_abs   <= '0;
            b_abs   <= '0;
            a_neg   <= 1'b0;
            b_neg   <= 1'b0;
            special <= 1'b0;
            acc     <= '0;
            count   <= '0;
            result  <= '0;
        end else begin
            case (state)
                S_IDLE: if (start && !kill) begin
                    op      <= funct3;
                    a_abs   <= rs1_abs;
                    b_abs   <= rs2_abs;
                    a_neg   <= rs1_neg;
                    b_neg   <= rs2_neg;
                    count   <= '0;
                    special <= div_zero || div_ovf || fast_mul;
                    if (div_zero)       acc <= {rs1_val, {XLEN{1'b1}}};
                    else if (div_ovf)   acc <= {{XLEN{1'b0}}, 1'b1, {(XLEN-1){1'b0}}};
                    else if (fast_mul)  acc <= fast_prod;
                    else if (funct3[2]) acc <= {{XLEN{1'b0}}, rs1_abs};
                    else                acc <= {{XLEN{1'b0}}, rs2_abs};
                end
                S_ITER: begin
                    acc   <= op[2] ? div_nxt : mul_nxt;
                    count <= (count == CW'(XLEN-1)) ? count : count + 1'b1;
                end
                S_FIX: if (!kill) result <= fix_val;
                default: ;
            endcase
        end
    end
endmodule
